// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - shared pipeline types and forwarding select encodings
package fwd_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    FWD_NONE        = 2'd0,
    FWD_FROM_EX_MEM = 2'd1,
    FWD_FROM_MEM_WB = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     reg_we;
    logic     is_load;
  } stage_entry_t;

  typedef struct packed {
    stage_entry_t base;
    reg_idx_t     rs1;
    reg_idx_t     rs2;
    logic         use_rs1;
    logic         use_rs2;
    logic         alu_src;
    logic         mem_we;
  } ex_entry_t;

  // True when the entry will write register r; register 0 is never a producer.
  function automatic logic writes_reg(input stage_entry_t e, input reg_idx_t r);
    return e.valid && e.reg_we && (e.rd != '0) && (e.rd == r);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_match.sv
// rtl/fwd_hazard_ctrl_match.sv - combinational operand compare against MEM and WB entries
module fwd_match
  import fwd_hazard_ctrl_pkg::*;
(
  input  reg_idx_t     src,
  input  logic         use_src,
  input  stage_entry_t mem,
  input  stage_entry_t wb,
  output logic [1:0]   sel
);

  // The MEM entry is the newer producer, so it wins over WB.
  always_comb begin
    sel = FWD_NONE;
    if (use_src && writes_reg(mem, src)) begin
      sel = FWD_FROM_EX_MEM;
    end else if (use_src && writes_reg(wb, src)) begin
      sel = FWD_FROM_MEM_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - pipeline stage tracker producing forwarding selects and load-use stalls
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_we,
  input  logic       id_is_load,
  input  logic       id_alu_src,
  input  logic       id_mem_we,
  input  logic       ex_flush,
  input  logic       mem_busy,
  output logic [1:0] op_a_sel,
  output logic [1:0] op_b_sel,
  output logic       alu_src,
  output logic       mem_we,
  output logic       stall_if_id,
  output logic       bubble_ex,
  output logic       freeze
);

  ex_entry_t    ex_q;
  ex_entry_t    id_entry;
  stage_entry_t mem_q;
  stage_entry_t wb_q;
  logic         load_use;
  logic         load_bubble;

  always_comb begin
    id_entry              = '0;
    id_entry.base.valid   = id_valid;
    id_entry.base.rd      = id_rd;
    id_entry.base.reg_we  = id_reg_we;
    id_entry.base.is_load = id_is_load;
    id_entry.rs1          = id_rs1;
    id_entry.rs2          = id_rs2;
    id_entry.use_rs1      = id_use_rs1;
    id_entry.use_rs2      = id_use_rs2;
    id_entry.alu_src      = id_alu_src;
    id_entry.mem_we       = id_mem_we;
  end

  // A load in EX cannot forward its data to the instruction right behind it.
  always_comb begin
    load_use = id_valid && ex_q.base.is_load &&
               ((id_use_rs1 && writes_reg(ex_q.base, id_rs1)) ||
                (id_use_rs2 && writes_reg(ex_q.base, id_rs2)));
  end

  assign load_bubble = load_use || ex_flush || !id_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!mem_busy) begin
      wb_q  <= mem_q;
      mem_q <= ex_q.base;
      ex_q  <= load_bubble ? '0 : id_entry;
    end
  end

  fwd_match u_fwd_a (
    .src     (ex_q.rs1),
    .use_src (ex_q.base.valid && ex_q.use_rs1),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (op_a_sel)
  );

  fwd_match u_fwd_b (
    .src     (ex_q.rs2),
    .use_src (ex_q.base.valid && ex_q.use_rs2),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (op_b_sel)
  );

  assign alu_src = ex_q.base.valid && ex_q.alu_src;
  assign mem_we  = ex_q.base.valid && ex_q.mem_we;

  // Flush overrides a load-use stall: the dependent instruction is being killed anyway.
  assign stall_if_id = reset_n && (mem_busy || (load_use && !ex_flush));
  assign bubble_ex   = reset_n && (load_use || ex_flush);
  assign freeze      = reset_n && mem_busy;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - vector table, corner sequences and random model check for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       we;
    logic       ld;
    logic       as;
    logic       mw;
  } ins_t;

  typedef struct packed {
    ins_t       id;
    logic       fl;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       es;
    logic       ebx;
    logic       eas;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_we, id_is_load, id_alu_src, id_mem_we;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_flush, mem_busy;
  logic [1:0] op_a_sel, op_b_sel;
  logic       alu_src, mem_we, stall_if_id, bubble_ex, freeze;

  int vecs = 0;
  int miscompares = 0;

  ins_t m_ex, m_mem, m_wb;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_we(id_reg_we), .id_is_load(id_is_load), .id_alu_src(id_alu_src),
    .id_mem_we(id_mem_we), .ex_flush(ex_flush), .mem_busy(mem_busy),
    .op_a_sel(op_a_sel), .op_b_sel(op_b_sel), .alu_src(alu_src), .mem_we(mem_we),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .freeze(freeze)
  );

  function automatic ins_t rtype(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t i = '0;
    i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1; i.we = 1'b1;
    return i;
  endfunction

  function automatic ins_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    ins_t i = '0;
    i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.u1 = 1'b1; i.we = 1'b1; i.ld = 1'b1; i.as = 1'b1;
    return i;
  endfunction

  function automatic ins_t nop();
    return '0;
  endfunction

  function automatic vec_t mkv(input ins_t id, input logic fl, input logic [1:0] ea, input logic [1:0] eb,
                               input logic es, input logic ebx, input logic eas);
    vec_t v;
    v.id = id; v.fl = fl; v.ea = ea; v.eb = eb; v.es = es; v.ebx = ebx; v.eas = eas;
    return v;
  endfunction

  task automatic drive(input ins_t i, input logic fl, input logic bz);
    id_valid = i.v; id_rd = i.rd; id_rs1 = i.rs1; id_rs2 = i.rs2;
    id_use_rs1 = i.u1; id_use_rs2 = i.u2; id_reg_we = i.we; id_is_load = i.ld;
    id_alu_src = i.as; id_mem_we = i.mw; ex_flush = fl; mem_busy = bz;
  endtask

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".op_a"}, op_a_sel, 2'd0);
    chk({nm, ".op_b"}, op_b_sel, 2'd0);
    chk({nm, ".alu_src"}, {1'b0, alu_src}, 2'd0);
    chk({nm, ".mem_we"}, {1'b0, mem_we}, 2'd0);
    chk({nm, ".stall"}, {1'b0, stall_if_id}, 2'd0);
    chk({nm, ".bubble"}, {1'b0, bubble_ex}, 2'd0);
    chk({nm, ".freeze"}, {1'b0, freeze}, 2'd0);
  endtask

  // Reference model: a producer is found by scanning older instructions, newest first.
  function automatic logic produces(input ins_t s, input logic [4:0] r);
    return s.v && s.we && (s.rd != 5'd0) && (s.rd == r);
  endfunction

  function automatic logic [1:0] model_sel(input logic [4:0] src, input logic use_it);
    ins_t older [2];
    older[0] = m_mem;
    older[1] = m_wb;
    if (!(m_ex.v && use_it)) return 2'd0;
    for (int k = 0; k < 2; k++)
      if (produces(older[k], src)) return 2'(k + 1);
    return 2'd0;
  endfunction

  task automatic reset_dut();
    reset_n = 1'b0;
    drive(nop(), 1'b0, 1'b0);
    m_ex = '0; m_mem = '0; m_wb = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t tbl [24];
    ins_t ri;
    logic rfl, rbz, lu;
    string nm;

    tbl[0]  = mkv(rtype(3, 1, 2),   0, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(rtype(4, 3, 5),   0, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(nop(),            0, 1, 0, 0, 0, 0);
    tbl[3]  = mkv(nop(),            0, 0, 0, 0, 0, 0);
    tbl[4]  = mkv(rtype(3, 1, 2),   0, 0, 0, 0, 0, 0);
    tbl[5]  = mkv(rtype(3, 4, 5),   0, 0, 0, 0, 0, 0);
    tbl[6]  = mkv(rtype(6, 7, 3),   0, 0, 0, 0, 0, 0);
    tbl[7]  = mkv(rtype(3, 1, 2),   0, 0, 1, 0, 0, 0);
    tbl[8]  = mkv(nop(),            0, 0, 0, 0, 0, 0);
    tbl[9]  = mkv(rtype(6, 7, 3),   0, 0, 0, 0, 0, 0);
    tbl[10] = mkv(nop(),            0, 0, 2, 0, 0, 0);
    tbl[11] = mkv(rtype(0, 1, 2),   0, 0, 0, 0, 0, 0);
    tbl[12] = mkv(rtype(5, 0, 0),   0, 0, 0, 0, 0, 0);
    tbl[13] = mkv(nop(),            0, 0, 0, 0, 0, 0);
    tbl[14] = mkv(lw(0, 1),         0, 0, 0, 0, 0, 0);
    tbl[15] = mkv(rtype(9, 0, 2),   0, 0, 0, 0, 0, 1);
    tbl[16] = mkv(nop(),            0, 0, 0, 0, 0, 0);
    tbl[17] = mkv(lw(8, 1),         0, 0, 0, 0, 0, 0);
    tbl[18] = mkv(rtype(9, 8, 2),   0, 0, 0, 1, 1, 1);
    tbl[19] = mkv(rtype(9, 8, 2),   0, 0, 0, 0, 0, 0);
    tbl[20] = mkv(nop(),            0, 2, 0, 0, 0, 0);
    tbl[21] = mkv(lw(10, 1),        0, 0, 0, 0, 0, 0);
    tbl[22] = mkv(rtype(11, 10, 2), 1, 0, 0, 0, 1, 1);
    tbl[23] = mkv(nop(),            0, 0, 0, 0, 0, 0);

    reset_n = 1'b0;
    drive(rtype(3, 1, 2), 1'b0, 1'b1);
    #2;
    chk_all_zero("reset");
    reset_dut();

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(tbl[i].id, tbl[i].fl, 1'b0);
      #2;
      nm = $sformatf("tbl%0d", i);
      chk({nm, ".op_a"}, op_a_sel, tbl[i].ea);
      chk({nm, ".op_b"}, op_b_sel, tbl[i].eb);
      chk({nm, ".stall"}, {1'b0, stall_if_id}, {1'b0, tbl[i].es});
      chk({nm, ".bubble"}, {1'b0, bubble_ex}, {1'b0, tbl[i].ebx});
      chk({nm, ".alu_src"}, {1'b0, alu_src}, {1'b0, tbl[i].eas});
    end

    // Freeze: three busy cycles with a flush pending must leave the entries untouched.
    reset_dut();
    @(negedge clk); drive(rtype(3, 1, 2), 1'b0, 1'b0);
    @(negedge clk); drive(rtype(4, 3, 5), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(rtype(12, 13, 14), 1'b1, 1'b1);
      #2;
      chk("freeze.op_a", op_a_sel, 2'd1);
      chk("freeze.op_b", op_b_sel, 2'd0);
      chk("freeze.stall", {1'b0, stall_if_id}, 2'd1);
      chk("freeze.freeze", {1'b0, freeze}, 2'd1);
    end
    @(negedge clk); drive(nop(), 1'b0, 1'b0);
    #2;
    chk("unfreeze.op_a", op_a_sel, 2'd1);
    chk("unfreeze.stall", {1'b0, stall_if_id}, 2'd0);
    @(negedge clk); #2;
    chk("unfreeze.shift", op_a_sel, 2'd0);

    // Reset asserted in the middle of a load-use stall.
    @(negedge clk); drive(lw(8, 1), 1'b0, 1'b0);
    @(negedge clk); drive(rtype(9, 8, 2), 1'b0, 1'b0);
    #2;
    chk("midstall.stall", {1'b0, stall_if_id}, 2'd1);
    #1 reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk); reset_n = 1'b1;
    #2;
    chk("post_reset.stall", {1'b0, stall_if_id}, 2'd0);
    chk("post_reset.bubble", {1'b0, bubble_ex}, 2'd0);

    // Random traffic against the reference model.
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      ri.v = ($urandom_range(0, 5) != 0);
      ri.rd = 5'($urandom_range(0, 3));
      ri.rs1 = 5'($urandom_range(0, 3));
      ri.rs2 = 5'($urandom_range(0, 3));
      ri.u1 = 1'($urandom); ri.u2 = 1'($urandom); ri.we = 1'($urandom);
      ri.ld = 1'($urandom); ri.as = 1'($urandom); ri.mw = 1'($urandom);
      rfl = ($urandom_range(0, 7) == 0);
      rbz = ($urandom_range(0, 7) == 0);
      drive(ri, rfl, rbz);
      #2;
      lu = ri.v && m_ex.ld && ((ri.u1 && produces(m_ex, ri.rs1)) || (ri.u2 && produces(m_ex, ri.rs2)));
      chk("rnd.op_a", op_a_sel, model_sel(m_ex.rs1, m_ex.u1));
      chk("rnd.op_b", op_b_sel, model_sel(m_ex.rs2, m_ex.u2));
      chk("rnd.alu_src", {1'b0, alu_src}, {1'b0, m_ex.v && m_ex.as});
      chk("rnd.mem_we", {1'b0, mem_we}, {1'b0, m_ex.v && m_ex.mw});
      chk("rnd.stall", {1'b0, stall_if_id}, {1'b0, rbz || (lu && !rfl)});
      chk("rnd.bubble", {1'b0, bubble_ex}, {1'b0, lu || rfl});
      chk("rnd.freeze", {1'b0, freeze}, {1'b0, rbz});
      if (!rbz) begin
        m_wb = m_mem;
        m_mem = m_ex;
        m_ex = (lu || rfl || !ri.v) ? nop() : ri;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
